// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic       REQ_IF    = 1'b0;
    localparam logic       REQ_D     = 1'b1;
    localparam logic [1:0] MASK_WORD = 2'b10;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified memory arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface unified_mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [1:0]            d_maskmode;
    logic                  d_sext;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_maskmode;
    logic                  mem_sext;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_maskmode, d_sext,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_maskmode, mem_sext,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_maskmode, d_sext,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_maskmode, mem_sext,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// UNIFIED_MEM_ARB_RR_EN selects round-robin on collision; otherwise data always wins.
module mem_arb_pick (
`ifdef UNIFIED_MEM_ARB_RR_EN
    input  logic last_gnt,
`endif
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);
`ifdef UNIFIED_MEM_ARB_RR_EN
    import mem_arb_pkg::*;

    // On a collision the port that was not granted last time wins.
    assign grant_d = d_req & (~if_req | (last_gnt == REQ_IF));
`else
    assign grant_d = d_req;
`endif
    assign grant_if = if_req & ~grant_d;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch and load/store ports.
// Define UNIFIED_MEM_ARB_RR_EN for round-robin collision handling.
module unified_mem_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    unified_mem_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t                state_q;
    logic                  owner_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [1:0]            mem_maskmode_q;
    logic                  mem_sext_q;
    logic                  if_rvalid_q;
    logic                  d_rvalid_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  pick_if;
    logic                  pick_d;
    logic                  grant_if;
    logic                  grant_d;

`ifdef UNIFIED_MEM_ARB_RR_EN
    logic last_gnt_q;
`endif

    mem_arb_pick u_pick (
`ifdef UNIFIED_MEM_ARB_RR_EN
        .last_gnt (last_gnt_q),
`endif
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .grant_if (pick_if),
        .grant_d  (pick_d)
    );

    // Grants exist only in IDLE; requests seen in ACCESS/RESP simply wait.
    assign grant_if = (state_q == IDLE) & pick_if;
    assign grant_d  = (state_q == IDLE) & pick_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= IDLE;
            owner_q        <= REQ_IF;
            cnt_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_maskmode_q <= 2'b00;
            mem_sext_q     <= 1'b0;
            if_rvalid_q    <= 1'b0;
            d_rvalid_q     <= 1'b0;
            if_rdata_q     <= '0;
            d_rdata_q      <= '0;
`ifdef UNIFIED_MEM_ARB_RR_EN
            last_gnt_q     <= REQ_IF;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q        <= REQ_D;
                        mem_we_q       <= bus.d_we;
                        mem_addr_q     <= bus.d_addr;
                        mem_wdata_q    <= bus.d_wdata;
                        mem_maskmode_q <= bus.d_maskmode;
                        mem_sext_q     <= bus.d_sext;
                    end else if (grant_if) begin
                        owner_q        <= REQ_IF;
                        mem_we_q       <= 1'b0;
                        mem_addr_q     <= bus.if_addr;
                        mem_wdata_q    <= '0;
                        mem_maskmode_q <= MASK_WORD;
                        mem_sext_q     <= 1'b0;
                    end
                    if (grant_d || grant_if) begin
                        mem_req_q  <= 1'b1;
                        cnt_q      <= CNT_W'(MEM_LATENCY - 1);
                        state_q    <= ACCESS;
`ifdef UNIFIED_MEM_ARB_RR_EN
                        last_gnt_q <= grant_d ? REQ_D : REQ_IF;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= RESP;
                        if (owner_q == REQ_IF) begin
                            if_rdata_q  <= bus.mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end else begin
                            // Stores acknowledge without disturbing the last load data.
                            if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
                            d_rvalid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if_rvalid_q <= 1'b0;
                    d_rvalid_q  <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt       = grant_if;
    assign bus.d_gnt        = grant_d;
    assign bus.if_rvalid    = if_rvalid_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.d_rvalid     = d_rvalid_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_maskmode = mem_maskmode_q;
    assign bus.mem_sext     = mem_sext_q;
    assign bus.busy         = (state_q != IDLE);

endmodule
